// File: rtl/aes_capture_pkg.sv
// Shared constants, FSM encodings and record word selection for the AES result capture block.
// Define AES_CAPTURE_CHECKSUM_EN to append an XOR checksum word to every record.
package aes_capture_pkg;
  localparam int WORD_W     = 32;
  localparam int DATA_WORDS = 12;
`ifdef AES_CAPTURE_CHECKSUM_EN
  localparam int REC_WORDS  = 13;
`else
  localparam int REC_WORDS  = 12;
`endif
  localparam int REC_W      = 384;
  localparam int WIDX_W     = 4;

  typedef enum logic {CD_IDLE, CD_WAIT} cd_state_t;
  typedef enum logic {ST_EMPTY, ST_SEND} st_state_t;

  // Word 0 is the MSW of the record ({key, state, aes_out}).
  function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                 input logic [WIDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] csum;
    w    = '0;
    csum = '0;
    for (int i = 0; i < DATA_WORDS; i++) begin
      if (idx == WIDX_W'(i)) w = rec[REC_W-1-i*WORD_W -: WORD_W];
      csum = csum ^ rec[REC_W-1-i*WORD_W -: WORD_W];
    end
`ifdef AES_CAPTURE_CHECKSUM_EN
    if (idx == WIDX_W'(DATA_WORDS)) w = csum;
`endif
    return w;
  endfunction
endpackage

// File: rtl/aes_result_capture_if.sv
// Valid/ready word stream carrying captured AES records.
interface aes_result_capture_if;
  import aes_capture_pkg::*;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/aes_capture_fifo.sv
// Record FIFO with same-cycle push/pop; exposes the head and the record behind it.
module aes_capture_fifo
  import aes_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         wdata,
  output logic [REC_W-1:0]         head,
  output logic [REC_W-1:0]         peek,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wp_q, rp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q[AW-1:0]] <= wdata;
  end

  assign count = wp_q - rp_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rp_q[AW-1:0]];
  // peek feeds the serializer when it rolls straight into the next record
  assign peek  = mem[rp_q[AW-1:0] + AW'(1)];
endmodule

// File: rtl/aes_result_capture.sv
// Captures {key, state, aes_out} LATENCY cycles after each launch and streams records as 32-bit words.
// Define AES_CAPTURE_CHECKSUM_EN to append an XOR checksum word to every record.
module aes_result_capture
  import aes_capture_pkg::*;
#(
  parameter int LATENCY = 31,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch,
  input  logic [127:0]        key,
  input  logic [127:0]        state,
  input  logic [127:0]        aes_out,
  aes_result_capture_if.master m,
  output logic [12:0]         sample_count,
  output logic                overflow,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDX_W-1:0] LAST_W = WIDX_W'(REC_WORDS-1);

  cd_state_t cd_q, cd_d;
  logic [7:0] cnt_q, cnt_d;
  logic       capture, push, pop, full, empty;
  logic [REC_W-1:0] head, peek;
  logic [AW:0] fcount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q  <= CD_IDLE;
      cnt_q <= '0;
    end else begin
      cd_q  <= cd_d;
      cnt_q <= cnt_d;
    end
  end

  // A launch always (re)starts the window, even on the cycle a capture completes.
  always_comb begin
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    capture = (cd_q == CD_WAIT) && (cnt_q == 8'd0);
    if (launch) begin
      cd_d  = CD_WAIT;
      cnt_d = 8'(LATENCY-1);
    end else if (cd_q == CD_WAIT) begin
      if (cnt_q == 8'd0) cd_d = CD_IDLE;
      else               cnt_d = cnt_q - 8'd1;
    end
  end

  assign push = capture && (!full || pop);

  aes_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({key, state, aes_out}),
    .head  (head),
    .peek  (peek),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push && sample_count != '1) sample_count <= sample_count + 13'd1;
      if (capture && !push)           overflow     <= 1'b1;
    end
  end

  assign busy = (cd_q == CD_WAIT) | !empty;

  st_state_t st_q, st_d;
  logic [WIDX_W-1:0] w_q, w_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= ST_EMPTY;
      w_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      w_q     <= w_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Outputs are registered; next word is chosen from FIFO state, never from m_ready into m_valid.
  always_comb begin
    st_d    = st_q;
    w_d     = w_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop     = 1'b0;
    case (st_q)
      ST_EMPTY: begin
        if (!empty) begin
          st_d    = ST_SEND;
          w_d     = '0;
          data_d  = rec_word(head, '0);
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (m.m_ready) begin
          if (w_q == LAST_W) begin
            pop    = 1'b1;
            w_d    = '0;
            last_d = 1'b0;
            if (fcount > (AW+1)'(1)) begin
              data_d = rec_word(peek, '0);
            end else begin
              st_d    = ST_EMPTY;
              valid_d = 1'b0;
              data_d  = '0;
            end
          end else begin
            w_d    = w_q + 4'd1;
            data_d = rec_word(head, w_q + 4'd1);
            last_d = (w_q + 4'd1 == LAST_W);
          end
        end
      end
      default: st_d = ST_EMPTY;
    endcase
  end

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
endmodule

// File: tb/tb_aes_result_capture.sv
// Directed bench for aes_result_capture: timing, ordering, backpressure, overflow, relaunch, async reset.
module tb_aes_result_capture;
  import aes_capture_pkg::*;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ST   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AOUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [31:0] EXP [12] = '{
    32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
    32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
    32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  localparam int NW = REC_WORDS;

  logic clk = 1'b0, rst = 1'b1, launch = 1'b0;
  logic [127:0] key = KEY, state = ST, aes_out = AOUT;
  logic [12:0] sample_count;
  logic overflow, busy;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] words[$];
  logic        lasts[$];

  aes_result_capture_if sif();

  aes_result_capture #(.LATENCY(31), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .launch(launch), .key(key), .state(state),
    .aes_out(aes_out), .m(sif), .sample_count(sample_count),
    .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] x;
    x = '0;
    if (i < 12) return EXP[i];
    for (int k = 0; k < 12; k++) x = x ^ EXP[k];
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!sif.m_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", sif.m_valid, 1'b1);
  endtask

  task automatic drain(input int n, input int budget, input bit toggle);
    bit held = 1'b0;
    logic [31:0] hd = '0;
    int k = 0;
    words.delete();
    lasts.delete();
    while (words.size() < n && k < budget) begin
      if (toggle) sif.m_ready = ~sif.m_ready;
      if (held) begin
        chk("hold_valid", sif.m_valid, 1'b1);
        chk("hold_data", sif.m_data, hd);
      end
      held = 1'b0;
      if (sif.m_valid && sif.m_ready) begin
        words.push_back(sif.m_data);
        lasts.push_back(sif.m_last);
      end else if (sif.m_valid) begin
        held = 1'b1;
        hd   = sif.m_data;
      end
      @(negedge clk);
      k++;
    end
    chk("drain_count", words.size(), n);
  endtask

  task automatic check_rec(input string tag);
    if (words.size() == NW) begin
      for (int i = 0; i < NW; i++) begin
        chk($sformatf("%s_w%0d", tag, i), words[i], exp_word(i));
        chk($sformatf("%s_last%0d", tag, i), lasts[i], (i == NW-1));
      end
    end
  endtask

  initial begin
    sif.m_ready = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", sif.m_valid, 1'b0);
    chk("rst_last", sif.m_last, 1'b0);
    chk("rst_data", sif.m_data, 32'h0);
    chk("rst_count", sample_count, 13'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(2);

    // single launch: capture on the 31st edge after launch, first word one edge later
    pulse();
    tick(30);
    chk("pre_cap_count", sample_count, 13'd0);
    chk("pre_cap_busy", busy, 1'b1);
    tick(1);
    chk("cap_count", sample_count, 13'd1);
    chk("cap_valid", sif.m_valid, 1'b0);
    tick(1);
    chk("first_valid", sif.m_valid, 1'b1);
    chk("first_data", sif.m_data, EXP[0]);
    drain(NW, 40, 1'b0);
    check_rec("single");
    tick(2);
    chk("single_idle_valid", sif.m_valid, 1'b0);
    chk("single_idle_busy", busy, 1'b0);

    // backpressure with m_ready toggling every cycle
    pulse();
    wait_valid(40);
    drain(NW, 100, 1'b1);
    check_rec("bp");
    chk("bp_count", sample_count, 13'd2);
    sif.m_ready = 1'b1;
    tick(3);
    chk("bp_idle_valid", sif.m_valid, 1'b0);

    // overflow: five launches 40 cycles apart with the sink stalled
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sif.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key[127:96] = 32'(i + 1);
      pulse();
      tick(32);
      if (i == 3) begin
        chk("ovf_pre_count", sample_count, 13'd4);
        chk("ovf_pre_flag", overflow, 1'b0);
      end
      if (i < 4) tick(7);
    end
    chk("ovf_count", sample_count, 13'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_busy", busy, 1'b1);
    chk("ovf_head", sif.m_data, 32'h1);
    sif.m_ready = 1'b1;
    drain(4*NW, 200, 1'b0);
    if (words.size() == 4*NW) begin
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("ovf_r%0d_w0", r), words[r*NW], 32'(r + 1));
        chk($sformatf("ovf_r%0d_last", r), lasts[r*NW+NW-1], 1'b1);
      end
    end
    tick(20);
    chk("ovf_no_extra", sif.m_valid, 1'b0);
    chk("ovf_busy_done", busy, 1'b0);
    key = KEY;

    // relaunch at cycle 10 of a countdown
    pulse();
    tick(9);
    pulse();
    tick(30);
    chk("relaunch_pre", sample_count, 13'd4);
    tick(1);
    chk("relaunch_cap", sample_count, 13'd5);
    wait_valid(5);
    drain(NW, 40, 1'b0);
    check_rec("relaunch");
    tick(40);
    chk("relaunch_single", sif.m_valid, 1'b0);
    chk("relaunch_count", sample_count, 13'd5);

    // asynchronous reset while word 5 is presented
    pulse();
    wait_valid(40);
    drain(5, 20, 1'b0);
    sif.m_ready = 1'b0;
    chk("mid_word5", sif.m_data, EXP[5]);
    rst = 1'b0;
    #1;
    chk("arst_valid", sif.m_valid, 1'b0);
    chk("arst_data", sif.m_data, 32'h0);
    chk("arst_last", sif.m_last, 1'b0);
    chk("arst_count", sample_count, 13'd0);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick(5);
    chk("arst_no_resume", sif.m_valid, 1'b0);
    sif.m_ready = 1'b1;
    pulse();
    wait_valid(40);
    drain(NW, 40, 1'b0);
    check_rec("post_rst");
    chk("post_rst_count", sample_count, 13'd1);

`ifdef AES_CAPTURE_CHECKSUM_EN
    key = {4{32'hA5A5A5A5}};
    state = {4{32'hA5A5A5A5}};
    aes_out = {4{32'hA5A5A5A5}};
    pulse();
    wait_valid(40);
    drain(13, 40, 1'b0);
    if (words.size() == 13) begin
      chk("csum_a5", words[12], 32'h00000000);
      chk("csum_a5_last", lasts[12], 1'b1);
    end
    aes_out[31:0] = 32'h00000001;
    pulse();
    wait_valid(40);
    drain(13, 40, 1'b0);
    if (words.size() == 13) begin
      chk("csum_w11", words[11], 32'h00000001);
      chk("csum_one", words[12], 32'hA5A5A5A4);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
